// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer: a one-entry register (SKID=0) or a two-entry skid
// buffer (SKID=1) between a valid/ready producer and consumer, with a
// synchronous flush for squashing in-flight entries.
module pipe_stage_buf #(
  parameter int unsigned      WIDTH      = 32,
  parameter bit               SKID       = 1'b1,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       count
);

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             in_xfer, out_xfer;
  logic             load_in, load_skid, fill_skid;
  logic [WIDTH-1:0] main_q, skid_q;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign count     = state;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Next-state and register load selects; flush overrides every transfer.
  always_comb begin
    state_nxt = state;
    load_in   = 1'b0;
    load_skid = 1'b0;
    fill_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_nxt = ONE;
            load_in   = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            state_nxt = FULL;
            fill_skid = 1'b1;
          end else if (out_xfer && !in_xfer) begin
            state_nxt = EMPTY;
          end else if (in_xfer && out_xfer) begin
            load_in = 1'b1;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_nxt = ONE;
            load_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Main register: the head entry presented downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            main_q <= RESET_DATA;
    else if (flush)     main_q <= RESET_DATA;
    else if (load_in)   main_q <= in_data;
    else if (load_skid) main_q <= skid_q;
  end

  generate
    if (SKID) begin : g_skid
      logic ready_q;

      // Skid register holds the entry that arrived while the head was stalled.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)            skid_q <= RESET_DATA;
        else if (flush)     skid_q <= RESET_DATA;
        else if (fill_skid) skid_q <= in_data;
      end

      // Registered ready breaks the out_ready -> in_ready timing path.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_q <= 1'b1;
        else     ready_q <= (state_nxt != FULL);
      end

      assign in_ready = ready_q;
    end else begin : g_noskid
      // Without a skid slot the stage can only accept when the head leaves.
      assign skid_q   = RESET_DATA;
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed vectors on a SKID=1 and a SKID=0 instance,
// asynchronous reset, then random traffic on four instances against a FIFO model.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  iv = '0, ordy = '0, fl = '0;
  logic [3:0]  ir, ov;
  logic [7:0]  cnt;
  logic [63:0] id [4];
  logic [31:0] od_a, od_b;
  logic        od_c;
  logic [63:0] od_d;
  logic [63:0] odx [4];

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] RD0 = 64'hDEAD_BEEF;
  localparam logic [63:0] RD2 = 64'h1;
  localparam logic [63:0] RD3 = 64'h0123_4567_89AB_CDEF;

  always #5 clk = ~clk;

  // inst 0: SKID=1 W=32; inst 1: SKID=0 W=32; inst 2: SKID=1 W=1; inst 3: SKID=1 W=64
  pipe_stage_buf #(.WIDTH(32), .SKID(1'b1), .RESET_DATA(RD0[31:0])) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(id[0][31:0]), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_data(od_a), .out_ready(ordy[0]), .flush(fl[0]), .count(cnt[1:0]));
  pipe_stage_buf #(.WIDTH(32), .SKID(1'b0), .RESET_DATA(32'h0)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(id[1][31:0]), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_data(od_b), .out_ready(ordy[1]), .flush(fl[1]), .count(cnt[3:2]));
  pipe_stage_buf #(.WIDTH(1), .SKID(1'b1), .RESET_DATA(RD2[0:0])) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_data(id[2][0:0]), .in_ready(ir[2]),
    .out_valid(ov[2]), .out_data(od_c), .out_ready(ordy[2]), .flush(fl[2]), .count(cnt[5:4]));
  pipe_stage_buf #(.WIDTH(64), .SKID(1'b1), .RESET_DATA(RD3)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_data(id[3]), .in_ready(ir[3]),
    .out_valid(ov[3]), .out_data(od_d), .out_ready(ordy[3]), .flush(fl[3]), .count(cnt[7:6]));

  assign odx[0] = {32'h0, od_a};
  assign odx[1] = {32'h0, od_b};
  assign odx[2] = {63'h0, od_c};
  assign odx[3] = od_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic [1:0]  cnt;
    logic        ov;
    logic [31:0] od;
    logic        chk_od;
    logic        ir;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int v, input int d, input int o, input int f,
                     input int c, input int eov, input int eod, input int ck, input int r);
    vec_t e;
    e.iv = (v != 0); e.d = d; e.ordy = (o != 0); e.fl = (f != 0);
    e.cnt = 2'(c); e.ov = (eov != 0); e.od = eod; e.chk_od = (ck != 0); e.ir = (r != 0);
    tbl.push_back(e);
  endtask

  // Random-phase reference: a bounded FIFO per instance.
  logic [63:0] mq [4][2];
  int          mc [4];
  logic [63:0] msk [4];
  bit          skid [4];

  initial begin
    for (int k = 0; k < 4; k++) id[k] = '0;
    msk[0] = 64'hFFFF_FFFF; msk[1] = 64'hFFFF_FFFF; msk[2] = 64'h1; msk[3] = '1;
    skid[0] = 1'b1; skid[1] = 1'b0; skid[2] = 1'b1; skid[3] = 1'b1;

    //       iv  d       ordy fl  cnt ov  od           chk ir
    add(1, 'h1,  1, 0,  1, 1, 'h1,         1, 1);   // streaming 1..4
    add(1, 'h2,  1, 0,  1, 1, 'h2,         1, 1);
    add(1, 'h3,  1, 0,  1, 1, 'h3,         1, 1);
    add(1, 'h4,  1, 0,  1, 1, 'h4,         1, 1);
    add(0, 'h0,  1, 0,  0, 0, 'h0,         0, 1);
    add(1, 'hA,  0, 0,  1, 1, 'hA,         1, 1);   // backpressure
    add(1, 'hB,  0, 0,  2, 1, 'hA,         1, 0);
    add(1, 'hE,  0, 0,  2, 1, 'hA,         1, 0);   // not accepted while full
    add(0, 'h0,  1, 0,  1, 1, 'hB,         1, 1);
    add(0, 'h0,  1, 0,  0, 0, 'h0,         0, 1);
    add(1, 'h10, 0, 0,  1, 1, 'h10,        1, 1);   // flush while full
    add(1, 'h11, 0, 0,  2, 1, 'h10,        1, 0);
    add(1, 'hC,  0, 1,  0, 0, 'hDEADBEEF,  1, 1);
    add(0, 'h0,  1, 0,  0, 0, 'hDEADBEEF,  1, 1);
    add(1, 'h20, 1, 0,  1, 1, 'h20,        1, 1);   // flush with both transfers
    add(1, 'h21, 1, 1,  0, 0, 'hDEADBEEF,  1, 1);
    add(1, 'h22, 0, 0,  1, 1, 'h22,        1, 1);
    add(1, 'h23, 1, 0,  1, 1, 'h23,        1, 1);   // replace head in ONE
    add(1, 'h24, 0, 0,  2, 1, 'h23,        1, 0);
    add(0, 'h0,  0, 0,  2, 1, 'h23,        1, 0);   // hold while stalled
    add(1, 'h25, 1, 0,  1, 1, 'h24,        1, 1);   // FULL drains, 0x25 refused
    add(1, 'h26, 1, 0,  1, 1, 'h26,        1, 1);

    // Reset held over a couple of edges, released away from the edge.
    step();
    step();
    #2 rst = 1'b0;
    step();
    chk("rst_cnt", {62'h0, cnt[1:0]}, 64'h0);
    chk("rst_ov", {63'h0, ov[0]}, 64'h0);
    chk("rst_od", odx[0], RD0);
    chk("rst_ir", {63'h0, ir[0]}, 64'h1);

    foreach (tbl[i]) begin
      iv[0] = tbl[i].iv; id[0] = {32'h0, tbl[i].d}; ordy[0] = tbl[i].ordy; fl[0] = tbl[i].fl;
      step();
      chk($sformatf("t%0d_cnt", i), {62'h0, cnt[1:0]}, {62'h0, tbl[i].cnt});
      chk($sformatf("t%0d_ov", i), {63'h0, ov[0]}, {63'h0, tbl[i].ov});
      chk($sformatf("t%0d_ir", i), {63'h0, ir[0]}, {63'h0, tbl[i].ir});
      if (tbl[i].chk_od) chk($sformatf("t%0d_od", i), odx[0], {32'h0, tbl[i].od});
    end
    iv[0] = 1'b0; fl[0] = 1'b0; ordy[0] = 1'b0;

    // SKID=0: in_ready follows out_ready combinationally when holding an entry.
    iv[1] = 1'b1; id[1] = 64'h7; ordy[1] = 1'b0;
    step();
    chk("s0_cnt1", {62'h0, cnt[3:2]}, 64'h1);
    chk("s0_od7", odx[1], 64'h7);
    chk("s0_ir_stall", {63'h0, ir[1]}, 64'h0);
    ordy[1] = 1'b1; id[1] = 64'h5;
    #1 chk("s0_ir_go", {63'h0, ir[1]}, 64'h1);
    step();
    chk("s0_od5", odx[1], 64'h5);
    chk("s0_cnt_keep", {62'h0, cnt[3:2]}, 64'h1);
    iv[1] = 1'b0; ordy[1] = 1'b0;
    #1 chk("s0_ir_drop", {63'h0, ir[1]}, 64'h0);
    ordy[1] = 1'b1;
    step();
    chk("s0_empty", {63'h0, ov[1]}, 64'h0);
    ordy[1] = 1'b0;

    // Asynchronous reset mid-cycle while inst 0 holds one entry.
    chk("ar_pre", {62'h0, cnt[1:0]}, 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("ar_ov", {63'h0, ov[0]}, 64'h0);
    chk("ar_od", odx[0], RD0);
    chk("ar_cnt", {62'h0, cnt[1:0]}, 64'h0);
    chk("ar_ir", {63'h0, ir[0]}, 64'h1);
    step();
    #2 rst = 1'b0;
    iv[0] = 1'b1; id[0] = 64'h33;
    step();
    chk("ar_after_cnt", {62'h0, cnt[1:0]}, 64'h1);
    chk("ar_after_od", odx[0], 64'h33);
    iv[0] = 1'b0;
    #2 rst = 1'b1;
    step();
    #2 rst = 1'b0;
    step();

    // Random traffic on all four instances.
    for (int k = 0; k < 4; k++) begin
      mc[k] = 0; mq[k][0] = '0; mq[k][1] = '0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("r%0d_cnt", k), {62'h0, cnt[2*k +: 2]}, 64'(mc[k]));
        chk($sformatf("r%0d_ov", k), {63'h0, ov[k]}, {63'h0, (mc[k] > 0)});
        if (mc[k] > 0) chk($sformatf("r%0d_od", k), odx[k], mq[k][0]);
        iv[k]   = ($urandom_range(0, 3) != 0);
        id[k]   = {$urandom, $urandom} & msk[k];
        ordy[k] = ($urandom_range(0, 2) != 0);
        fl[k]   = ($urandom_range(0, 15) == 0);
      end
      #1;
      for (int k = 0; k < 4; k++) begin
        bit exp_ir, acc, del;
        exp_ir = skid[k] ? (mc[k] < 2) : (mc[k] == 0 || ordy[k]);
        chk($sformatf("r%0d_ir", k), {63'h0, ir[k]}, {63'h0, exp_ir});
        acc = iv[k] && exp_ir;
        del = (mc[k] > 0) && ordy[k];
        if (fl[k]) begin
          mc[k] = 0;
        end else begin
          if (del) begin
            mq[k][0] = mq[k][1];
            mc[k]--;
          end
          if (acc && mc[k] < 2) begin
            mq[k][mc[k]] = id[k];
            mc[k]++;
          end
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
